// File: rtl/mem_credit_sched.sv
// Credit-limited round-robin scheduler. It shares one memory request port among
// NUM_REQS clients and steers responses back to their owners by tag.
module mem_credit_sched #(
    parameter int NUM_REQS      = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int MAX_CREDITS   = 4,
    parameter int LOG_NUM_REQS  = $clog2(NUM_REQS),
    parameter int CNT_WIDTH     = $clog2(MAX_CREDITS + 1),
    parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]   req_tag_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]     req_addr_in,
    input  logic [NUM_REQS-1:0]                req_rw_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]     req_data_in,
    output logic [NUM_REQS-1:0]                req_ready_in,
    output logic                               req_valid_out,
    output logic [TAG_OUT_WIDTH-1:0]           req_tag_out,
    output logic [ADDR_WIDTH-1:0]              req_addr_out,
    output logic                               req_rw_out,
    output logic [DATA_WIDTH-1:0]              req_data_out,
    input  logic                               req_ready_out,
    input  logic                               rsp_valid_in,
    input  logic [TAG_OUT_WIDTH-1:0]           rsp_tag_in,
    input  logic [DATA_WIDTH-1:0]              rsp_data_in,
    output logic                               rsp_ready_in,
    output logic [NUM_REQS-1:0]                rsp_valid_out,
    output logic [TAG_IN_WIDTH-1:0]            rsp_tag_out,
    output logic [DATA_WIDTH-1:0]              rsp_data_out,
    input  logic [NUM_REQS-1:0]                rsp_ready_out,
    output logic [NUM_REQS*CNT_WIDTH-1:0]      credits_out,
    output logic                               idle,
    output logic                               err
);

    logic                                slot_valid_r;
    logic [TAG_OUT_WIDTH-1:0]            slot_tag_r;
    logic [ADDR_WIDTH-1:0]               slot_addr_r;
    logic                                slot_rw_r;
    logic [DATA_WIDTH-1:0]               slot_data_r;
    logic [LOG_NUM_REQS-1:0]             rr_ptr_r;
    logic [NUM_REQS-1:0][CNT_WIDTH-1:0]  cnt_r;
    logic                                err_r;

    logic [NUM_REQS-1:0]     eligible_s;
    logic                    grant_valid_s;
    logic [LOG_NUM_REQS-1:0] grant_idx_s;
    logic                    load_en_s;
    logic                    accept_s;
    logic [TAG_IN_WIDTH-1:0] grant_tag_s;
    logic [ADDR_WIDTH-1:0]   grant_addr_s;
    logic                    grant_rw_s;
    logic [DATA_WIDTH-1:0]   grant_data_s;
    logic [NUM_REQS-1:0]     inc_s;
    logic [NUM_REQS-1:0]     dec_s;
    logic                    sel_ok_s;
    logic                    err_set_s;

    assign load_en_s = !slot_valid_r || req_ready_out;
    assign accept_s  = load_en_s && grant_valid_s;

    // Eligibility: writes always, reads only while credits remain.
    always_comb begin
        eligible_s = {NUM_REQS{1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible_s[i] = req_valid_in[i] &&
                            (req_rw_in[i] || (cnt_r[i] < CNT_WIDTH'(MAX_CREDITS)));
        end
    end

    // Round-robin search from rr_ptr; walking backwards leaves the first hit as winner.
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_s = 1'b0;
        grant_idx_s   = {LOG_NUM_REQS{1'b0}};
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr_r) + k) % NUM_REQS;
            if (eligible_s[idx]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = LOG_NUM_REQS'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Payload mux, per-requester accept and credit increment.
    always_comb begin
        grant_tag_s  = {TAG_IN_WIDTH{1'b0}};
        grant_addr_s = {ADDR_WIDTH{1'b0}};
        grant_rw_s   = 1'b0;
        grant_data_s = {DATA_WIDTH{1'b0}};
        req_ready_in = {NUM_REQS{1'b0}};
        inc_s        = {NUM_REQS{1'b0}};
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant_idx_s == LOG_NUM_REQS'(i)) begin
                grant_tag_s     = req_tag_in[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
                grant_addr_s    = req_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
                grant_rw_s      = req_rw_in[i];
                grant_data_s    = req_data_in[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready_in[i] = accept_s;
                inc_s[i]        = accept_s && !req_rw_in[i];
            end else begin
                req_ready_in[i] = 1'b0;
            end
        end
    end

    // Response demux; an out-of-range index is swallowed so the port cannot lock up.
    always_comb begin
        rsp_valid_out = {NUM_REQS{1'b0}};
        rsp_ready_in  = 1'b1;
        sel_ok_s      = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (rsp_tag_in[LOG_NUM_REQS-1:0] == LOG_NUM_REQS'(i)) begin
                rsp_valid_out[i] = rsp_valid_in;
                rsp_ready_in     = rsp_ready_out[i];
                sel_ok_s         = 1'b1;
            end else begin
                rsp_valid_out[i] = 1'b0;
            end
        end
    end

    // Credit return and protocol-error detection.
    always_comb begin
        dec_s     = rsp_valid_out & rsp_ready_out;
        err_set_s = rsp_valid_in && !sel_ok_s;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (dec_s[i] && (cnt_r[i] == {CNT_WIDTH{1'b0}})) begin
                err_set_s = 1'b1;
            end else begin
                err_set_s = err_set_s;
            end
        end
    end

    assign rsp_tag_out  = rsp_tag_in[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
    assign rsp_data_out = rsp_data_in;

    // Output slot and round-robin pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_valid_r <= 1'b0;
            slot_tag_r   <= {TAG_OUT_WIDTH{1'b0}};
            slot_addr_r  <= {ADDR_WIDTH{1'b0}};
            slot_rw_r    <= 1'b0;
            slot_data_r  <= {DATA_WIDTH{1'b0}};
            rr_ptr_r     <= {LOG_NUM_REQS{1'b0}};
        end else if (load_en_s) begin
            slot_valid_r <= accept_s;
            if (accept_s) begin
                slot_tag_r  <= {grant_tag_s, grant_idx_s};
                slot_addr_r <= grant_addr_s;
                slot_rw_r   <= grant_rw_s;
                slot_data_r <= grant_data_s;
                if (grant_idx_s == LOG_NUM_REQS'(NUM_REQS - 1)) begin
                    rr_ptr_r <= {LOG_NUM_REQS{1'b0}};
                end else begin
                    rr_ptr_r <= grant_idx_s + LOG_NUM_REQS'(1);
                end
            end
        end
    end

    // Outstanding-read counters (saturate at zero) and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {(NUM_REQS*CNT_WIDTH){1'b0}};
            err_r <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            for (int i = 0; i < NUM_REQS; i++) begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_r[i] <= cnt_r[i] + CNT_WIDTH'(1);
                    2'b01: begin
                        if (cnt_r[i] != {CNT_WIDTH{1'b0}}) begin
                            cnt_r[i] <= cnt_r[i] - CNT_WIDTH'(1);
                        end else begin
                            cnt_r[i] <= cnt_r[i];
                        end
                    end
                    default: cnt_r[i] <= cnt_r[i];
                endcase
            end
        end
    end

    assign req_valid_out = slot_valid_r;
    assign req_tag_out   = slot_tag_r;
    assign req_addr_out  = slot_addr_r;
    assign req_rw_out    = slot_rw_r;
    assign req_data_out  = slot_data_r;
    assign credits_out   = cnt_r;
    assign err           = err_r;
    assign idle          = !slot_valid_r && (cnt_r == {(NUM_REQS*CNT_WIDTH){1'b0}});

endmodule

// File: tb/tb_mem_credit_sched.sv
// Directed self-checking bench for mem_credit_sched (4 requesters, plus a
// 3-requester instance for the out-of-range response index).
module tb_mem_credit_sched;

    logic clk;
    logic reset;

    logic [3:0]   req_valid_in;
    logic [31:0]  req_tag_in;
    logic [127:0] req_addr_in;
    logic [3:0]   req_rw_in;
    logic [255:0] req_data_in;
    logic [3:0]   req_ready_in;
    logic         req_valid_out;
    logic [9:0]   req_tag_out;
    logic [31:0]  req_addr_out;
    logic         req_rw_out;
    logic [63:0]  req_data_out;
    logic         req_ready_out;
    logic         rsp_valid_in;
    logic [9:0]   rsp_tag_in;
    logic [63:0]  rsp_data_in;
    logic         rsp_ready_in;
    logic [3:0]   rsp_valid_out;
    logic [7:0]   rsp_tag_out;
    logic [63:0]  rsp_data_out;
    logic [3:0]   rsp_ready_out;
    logic [11:0]  credits_out;
    logic         idle;
    logic         err;

    logic [2:0]   r3_req_ready_in;
    logic         r3_req_valid_out;
    logic [9:0]   r3_req_tag_out;
    logic [31:0]  r3_req_addr_out;
    logic         r3_req_rw_out;
    logic [63:0]  r3_req_data_out;
    logic         r3_rsp_valid_in;
    logic [9:0]   r3_rsp_tag_in;
    logic         r3_rsp_ready_in;
    logic [2:0]   r3_rsp_valid_out;
    logic [7:0]   r3_rsp_tag_out;
    logic [63:0]  r3_rsp_data_out;
    logic [2:0]   r3_rsp_ready_out;
    logic [8:0]   r3_credits_out;
    logic         r3_idle;
    logic         r3_err;

    int n_checks = 0;
    int n_errors = 0;
    int accepted;

    mem_credit_sched dut (
        .clk(clk), .reset(reset),
        .req_valid_in(req_valid_in), .req_tag_in(req_tag_in), .req_addr_in(req_addr_in),
        .req_rw_in(req_rw_in), .req_data_in(req_data_in), .req_ready_in(req_ready_in),
        .req_valid_out(req_valid_out), .req_tag_out(req_tag_out), .req_addr_out(req_addr_out),
        .req_rw_out(req_rw_out), .req_data_out(req_data_out), .req_ready_out(req_ready_out),
        .rsp_valid_in(rsp_valid_in), .rsp_tag_in(rsp_tag_in), .rsp_data_in(rsp_data_in),
        .rsp_ready_in(rsp_ready_in), .rsp_valid_out(rsp_valid_out), .rsp_tag_out(rsp_tag_out),
        .rsp_data_out(rsp_data_out), .rsp_ready_out(rsp_ready_out),
        .credits_out(credits_out), .idle(idle), .err(err)
    );

    mem_credit_sched #(.NUM_REQS(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid_in(3'b000), .req_tag_in(24'h000000), .req_addr_in(96'h0),
        .req_rw_in(3'b000), .req_data_in(192'h0), .req_ready_in(r3_req_ready_in),
        .req_valid_out(r3_req_valid_out), .req_tag_out(r3_req_tag_out),
        .req_addr_out(r3_req_addr_out), .req_rw_out(r3_req_rw_out),
        .req_data_out(r3_req_data_out), .req_ready_out(1'b1),
        .rsp_valid_in(r3_rsp_valid_in), .rsp_tag_in(r3_rsp_tag_in), .rsp_data_in(64'h0),
        .rsp_ready_in(r3_rsp_ready_in), .rsp_valid_out(r3_rsp_valid_out),
        .rsp_tag_out(r3_rsp_tag_out), .rsp_data_out(r3_rsp_data_out),
        .rsp_ready_out(r3_rsp_ready_out), .credits_out(r3_credits_out),
        .idle(r3_idle), .err(r3_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset           = 1'b0;
        req_valid_in    = 4'b0000;
        req_rw_in       = 4'b0000;
        req_ready_out   = 1'b1;
        rsp_valid_in    = 1'b0;
        rsp_tag_in      = 10'h000;
        rsp_data_in     = 64'h0;
        rsp_ready_out   = 4'b0000;
        r3_rsp_valid_in = 1'b0;
        r3_rsp_tag_in   = 10'h000;
        r3_rsp_ready_out = 3'b000;
        for (int i = 0; i < 4; i++) begin
            req_tag_in[i*8 +: 8]    = 8'h10 + 8'(i);
            req_addr_in[i*32 +: 32] = 32'h0000_1000 + 32'(i);
            req_data_in[i*64 +: 64] = 64'hD000_0000_0000_0000 + 64'(i);
        end

        // Reset state
        #12;
        check_eq("rst_valid", 64'(req_valid_out), 64'h0);
        check_eq("rst_credits", 64'(credits_out), 64'h0);
        check_eq("rst_err", 64'(err), 64'h0);
        check_eq("rst_idle", 64'(idle), 64'h1);
        tick();
        reset = 1'b1;

        // Out-of-range response index on the 3-requester instance
        r3_rsp_valid_in = 1'b1;
        r3_rsp_tag_in   = {8'hAB, 2'd3};
        #1;
        check_eq("r3_ready", 64'(r3_rsp_ready_in), 64'h1);
        check_eq("r3_valid_out", 64'(r3_rsp_valid_out), 64'h0);
        check_eq("r3_err_pre", 64'(r3_err), 64'h0);
        tick();
        r3_rsp_valid_in = 1'b0;
        check_eq("r3_err", 64'(r3_err), 64'h1);

        // Round-robin writes from all requesters
        req_valid_in = 4'b1111;
        req_rw_in    = 4'b1111;
        #1;
        for (int k = 0; k < 6; k++) begin
            check_eq("rr_grant", 64'(req_ready_in), 64'(4'b0001 << (k % 4)));
            tick();
            check_eq("rr_valid", 64'(req_valid_out), 64'h1);
            check_eq("rr_tag_lsb", 64'(req_tag_out[1:0]), 64'(k % 4));
        end
        check_eq("rr_tag_full", 64'(req_tag_out), 64'h045);
        check_eq("rr_credits", 64'(credits_out), 64'h0);
        req_valid_in = 4'b0000;
        tick();

        // Credit limit: requester 2 asks for 6 reads
        req_valid_in = 4'b0100;
        req_rw_in    = 4'b0000;
        #1;
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            if (req_ready_in[2]) accepted++;
            tick();
        end
        check_eq("cl_accepted", 64'(accepted), 64'h4);
        check_eq("cl_credits", 64'(credits_out), 64'h100);
        check_eq("cl_ready_blocked", 64'(req_ready_in), 64'h0);
        check_eq("cl_idle", 64'(idle), 64'h0);
        req_valid_in = 4'b0101;
        req_rw_in    = 4'b0001;
        #1;
        check_eq("cl_other_granted", 64'(req_ready_in), 64'h1);
        tick();

        // Credit return
        req_valid_in  = 4'b0100;
        req_rw_in     = 4'b0000;
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h5A, 2'd2};
        rsp_data_in   = 64'hCAFE_F00D_1234_5678;
        rsp_ready_out = 4'b0100;
        #1;
        check_eq("ret_valid_out", 64'(rsp_valid_out), 64'h4);
        check_eq("ret_tag_out", 64'(rsp_tag_out), 64'h5A);
        check_eq("ret_data_out", rsp_data_out, 64'hCAFE_F00D_1234_5678);
        check_eq("ret_rsp_ready", 64'(rsp_ready_in), 64'h1);
        check_eq("ret_not_yet", 64'(req_ready_in), 64'h0);
        tick();
        check_eq("ret_credits", 64'(credits_out), 64'h0C0);
        check_eq("ret_reaccept", 64'(req_ready_in), 64'h4);
        tick();
        check_eq("simul_credits", 64'(credits_out), 64'h0C0);
        rsp_valid_in = 1'b0;
        #1;
        check_eq("simul_ready", 64'(req_ready_in), 64'h4);
        tick();
        check_eq("refill_credits", 64'(credits_out), 64'h100);
        check_eq("refill_blocked", 64'(req_ready_in), 64'h0);

        // Backpressure with a read from requester 2 in the slot
        req_ready_out = 1'b0;
        req_valid_in  = 4'b0010;
        req_rw_in     = 4'b0010;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_eq("bp_ready_in", 64'(req_ready_in), 64'h0);
            check_eq("bp_valid", 64'(req_valid_out), 64'h1);
            check_eq("bp_tag", 64'(req_tag_out), 64'h04A);
            check_eq("bp_addr", 64'(req_addr_out), 64'h1002);
            check_eq("bp_rw", 64'(req_rw_out), 64'h0);
            tick();
        end
        req_ready_out = 1'b1;
        #1;
        check_eq("bp_release_ready", 64'(req_ready_in), 64'h2);
        tick();
        check_eq("bp_reload_tag", 64'(req_tag_out), 64'h045);
        check_eq("bp_reload_rw", 64'(req_rw_out), 64'h1);
        check_eq("bp_reload_data", req_data_out, 64'hD000_0000_0000_0001);
        req_valid_in = 4'b0000;
        tick();
        check_eq("bp_drained", 64'(req_valid_out), 64'h0);

        // Response to a requester with no reads outstanding
        check_eq("err_pre", 64'(err), 64'h0);
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h33, 2'd0};
        rsp_ready_out = 4'b0001;
        #1;
        check_eq("err_delivered", 64'(rsp_valid_out), 64'h1);
        check_eq("err_tag", 64'(rsp_tag_out), 64'h33);
        tick();
        rsp_valid_in = 1'b0;
        check_eq("err_set", 64'(err), 64'h1);
        check_eq("err_cnt_sat", 64'(credits_out), 64'h100);
        tick();
        check_eq("err_sticky", 64'(err), 64'h1);

        // Async reset with 3 reads outstanding and the slot loaded
        req_valid_in  = 4'b0001;
        req_rw_in     = 4'b0001;
        rsp_valid_in  = 1'b1;
        rsp_tag_in    = {8'h5A, 2'd2};
        rsp_ready_out = 4'b0100;
        tick();
        req_valid_in = 4'b0000;
        rsp_valid_in = 1'b0;
        #1;
        check_eq("ar_pre_credits", 64'(credits_out), 64'h0C0);
        check_eq("ar_pre_valid", 64'(req_valid_out), 64'h1);
        check_eq("ar_pre_idle", 64'(idle), 64'h0);
        #1;
        reset = 1'b0;
        #1;
        check_eq("ar_valid", 64'(req_valid_out), 64'h0);
        check_eq("ar_credits", 64'(credits_out), 64'h0);
        check_eq("ar_err", 64'(err), 64'h0);
        check_eq("ar_idle", 64'(idle), 64'h1);
        check_eq("ar_r3_err", 64'(r3_err), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
